four_way_rr_arbiter: RTL and testbench
======================================

# four_way_rr_arbiter

Round-robin arbiter sharing one resource among four requesters. The winner is held as a 2-bit index and driven out one-hot through a 2-to-4 decoder stage. Each grant is held until the owner signals done, drops its request, or exceeds a hold limit. The block sits in front of any single-port resource in the lab datapath, such as a shared register, display or bus, and replaces hand-wired priority logic.

## Interface
- MAX_HOLD, default 8: maximum number of cycles one grant may be held (legal range 2..255).
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  4  request lines; bit i = requester i.
- done  in  4  release strobe; bit i is meaningful only while requester i holds the grant.
- grant  out  4  one-hot grant; all zeros when idle.
- grant_id  out  2  index of the current owner; 0 when grant_valid=0.
- grant_valid  out  1  high while any grant is active.
- timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

## Operation
- State machine has three states: IDLE, GRANT, RELEASE. Reset state is IDLE.
- IDLE:
  - If req≠0, arbitrate and go to GRANT.
  - Otherwise stay in IDLE.
- Arbitration uses the registered pointer last (2 bits, reset 2'd3).
  - Search order: last+1, last+2, last+3, last, all modulo 4.
  - The first set req bit in that order wins.
  - The winner is loaded into grant_id and into last; the hold counter is cleared.
- GRANT:
  - Release when done[grant_id]=1, when req[grant_id]=0, or when hold counter = MAX_HOLD-1. Release goes to RELEASE.
  - If both done and the limit hit in the same cycle, done takes priority: no timeout pulse.
  - done bits of non-owners are ignored.
  - req changes on other lines never preempt the owner.
- RELEASE:
  - Exactly one cycle with grant=0 and grant_valid=0 (bus turnaround).
  - If req≠0, arbitrate (using the updated last) and go to GRANT; otherwise go to IDLE.
- Hold counter:
  - Width is ceil(log2(MAX_HOLD)).
  - Increments every cycle in GRANT and saturates (never wraps).
  - Cleared on each new grant.
- grant is the decoded grant_id gated by grant_valid. Exactly one bit is high, or none.
- Reset outputs: grant=4'b0000, grant_id=2'b00, grant_valid=0, timeout=0. Internal reset values: last=2'd3, counter=0, state IDLE.

## Timing
- Request-to-grant latency: req sampled at edge k in IDLE → grant valid after edge k (visible cycle k+1). All outputs are registered.
- Release: condition sampled at edge k → grant=0 in cycle k+1 (RELEASE).
  - A new grant, if any req is pending, becomes visible in cycle k+2.
- Back-to-back ownership changes therefore cost one dead cycle.
- Maximum hold: owner keeps grant for exactly MAX_HOLD cycles. timeout is high in the first RELEASE cycle only.
- A requester holding req continuously with all others idle is regranted after each dead cycle.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,... Any requester waits at most 3 grants.
- Synchronous reset mid-grant: at the next edge grant drops to 0, state goes to IDLE, and last returns to 3. No timeout pulse.
- rst has priority over every other input in the same cycle.

## Structure
- Shared package holds:
  - the state encoding (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2; 2'd3 illegal, recovers to IDLE);
  - the pointer reset constant (2'd3);
  - the requester count constant (4).
- One sub-module, grant_onehot_decoder: combinational 2-bit index plus enable → 4-bit one-hot. Instantiated once for the grant output.
- The round-robin search is a combinational function in the top module. The FSM, pointer and counter are in one clocked process.

## Test plan
- Reset, then req=4'b0000 for 10 cycles → grant=0, grant_valid=0, state stays IDLE, timeout never pulses.
- req=4'b1111 held, done pulsed by each owner one cycle after its grant → grant sequence 0001,0010,0100,1000,0001, with one zero cycle between each.
- req=4'b0001 only, never done, MAX_HOLD=8 → grant=0001 for exactly 8 cycles, then timeout=1 with grant=0 for one cycle, then grant=0001 again.
- Owner 2 granted; done=4'b0001 (non-owner) → ignored. Then req[2] dropped → release next edge, no timeout.
- done[id] and the hold limit in the same cycle → release with timeout=0.
- rst asserted mid-grant of requester 1 → next cycle grant=0. With req=4'b0011 after reset, the first grant is requester 0.

Source files
------------

// File: rtl/four_way_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : four_way_rr_arbiter_pkg
// Brief  : Shared constants for the four-way round-robin arbiter.
// Rev    : 1.0
// ============================================================================
package four_way_rr_arbiter_pkg;

   localparam int         NUM_REQ    = 4;
   localparam logic [1:0] LAST_RST   = 2'd3;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

endpackage : four_way_rr_arbiter_pkg
`default_nettype wire

// File: rtl/four_way_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : four_way_rr_arbiter_if
// Brief  : Request/grant bundle between requesters and the arbiter.
// Rev    : 1.0
// ============================================================================
interface four_way_rr_arbiter_if;
   import four_way_rr_arbiter_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] done;
   logic [NUM_REQ-1:0] grant;
   logic [1:0]         grant_id;
   logic               grant_valid;
   logic               timeout;

   modport slave  (input req, input done,
                   output grant, output grant_id, output grant_valid, output timeout);
   modport master (output req, output done,
                   input grant, input grant_id, input grant_valid, input timeout);
endinterface : four_way_rr_arbiter_if
`default_nettype wire

// File: rtl/four_way_rr_arbiter_grant_onehot_decoder.sv
`default_nettype none
// ============================================================================
// Module : grant_onehot_decoder
// Brief  : 2-bit index plus enable to 4-bit one-hot.
// Rev    : 1.0
// ============================================================================
module grant_onehot_decoder (
   input  logic [1:0] idx_i,
   input  logic       en_i,
   output logic [3:0] onehot_o
);

   assign onehot_o = en_i ? (4'b0001 << idx_i) : 4'b0000;

endmodule : grant_onehot_decoder
`default_nettype wire

// File: rtl/four_way_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : four_way_rr_arbiter
// Brief  : Round-robin arbiter for four requesters with a hold-time limit.
// Rev    : 1.0
// ============================================================================
module four_way_rr_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   four_way_rr_arbiter_if.slave  bus
);
   import four_way_rr_arbiter_pkg::*;

   localparam int              CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   // Earliest position in last+1 .. last+4 wins; scanning backwards lets it overwrite later ones.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
      logic [1:0] idx;
      rr_pick = last;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = last + 2'(i);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

   logic [1:0]       state_q;
   logic [1:0]       last_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       grant_id_q;
   logic             grant_valid_q;
   logic             timeout_q;

   logic [1:0]       win_d;
   logic [CNT_W-1:0] cnt_d;
   logic             any_req;
   logic             owner_done;
   logic             owner_drop;
   logic             hold_hit;
   logic [3:0]       grant_dec;

   assign any_req    = |bus.req;
   assign win_d      = rr_pick(bus.req, last_q);
   assign cnt_d      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
   assign owner_done = bus.done[last_q];
   assign owner_drop = ~bus.req[last_q];
   assign hold_hit   = (cnt_q == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         last_q        <= LAST_RST;
         cnt_q         <= '0;
         grant_id_q    <= 2'd0;
         grant_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_RELEASE: begin
               if (any_req) begin
                  state_q       <= ST_GRANT;
                  last_q        <= win_d;
                  grant_id_q    <= win_d;
                  grant_valid_q <= 1'b1;
                  cnt_q         <= '0;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               if (owner_done || owner_drop || hold_hit) begin
                  state_q       <= ST_RELEASE;
                  grant_id_q    <= 2'd0;
                  grant_valid_q <= 1'b0;
                  // Only a forced release reports a timeout; any voluntary release wins.
                  timeout_q     <= hold_hit && !owner_done && !owner_drop;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q       <= ST_IDLE;
               grant_id_q    <= 2'd0;
               grant_valid_q <= 1'b0;
            end
         endcase
      end
   end

   grant_onehot_decoder u_grant_dec (
      .idx_i    (grant_id_q),
      .en_i     (grant_valid_q),
      .onehot_o (grant_dec)
   );

   assign bus.grant       = grant_dec;
   assign bus.grant_id    = grant_id_q;
   assign bus.grant_valid = grant_valid_q;
   assign bus.timeout     = timeout_q;

endmodule : four_way_rr_arbiter
`default_nettype wire

// File: tb/tb_four_way_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_four_way_rr_arbiter
// Brief  : Directed, table-driven self-checking bench for four_way_rr_arbiter.
// Rev    : 1.0
// ============================================================================
module tb_four_way_rr_arbiter;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] done;
      logic [3:0] eg;
      logic [1:0] eid;
      logic       ev;
      logic       eto;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   four_way_rr_arbiter_if bus ();

   four_way_rr_arbiter #(.MAX_HOLD(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic vec_t v(logic r, logic [3:0] rq, logic [3:0] dn,
                              logic [3:0] g, logic [1:0] id, logic vl, logic to);
      vec_t x;
      x.rst = r; x.req = rq; x.done = dn;
      x.eg = g; x.eid = id; x.ev = vl; x.eto = to;
      return x;
   endfunction

   task automatic check(string name, logic [3:0] g, logic [1:0] id, logic vl, logic to);
      total++;
      if ({bus.grant, bus.grant_id, bus.grant_valid, bus.timeout} !== {g, id, vl, to}) begin
         bad++;
         $display("FAIL %s: got grant=%b id=%0d valid=%b timeout=%b, want grant=%b id=%0d valid=%b timeout=%b",
                  name, bus.grant, bus.grant_id, bus.grant_valid, bus.timeout, g, id, vl, to);
      end
   endtask

   task automatic step(logic r, logic [3:0] rq, logic [3:0] dn);
      rst      = r;
      bus.req  = rq;
      bus.done = dn;
      @(posedge clk);
      #1;
   endtask

   task automatic run_table(string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].req, tbl[i].done);
         check($sformatf("%s[%0d]", tag, i), tbl[i].eg, tbl[i].eid, tbl[i].ev, tbl[i].eto);
      end
      tbl.delete();
   endtask

   initial begin
      rst      = 1'b1;
      bus.req  = 4'b0000;
      bus.done = 4'b0000;

      // Reset and idle
      tbl.push_back(v(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0));
      for (int i = 0; i < 10; i++)
         tbl.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0));
      // All requesting, each owner releases one cycle after its grant
      tbl.push_back(v(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0));
      tbl.push_back(v(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0, 0));
      tbl.push_back(v(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1, 0));
      tbl.push_back(v(0, 4'b1111, 4'b0010, 4'b0000, 2'd0, 0, 0));
      tbl.push_back(v(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1, 0));
      tbl.push_back(v(0, 4'b1111, 4'b0100, 4'b0000, 2'd0, 0, 0));
      tbl.push_back(v(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1, 0));
      tbl.push_back(v(0, 4'b1111, 4'b1000, 4'b0000, 2'd0, 0, 0));
      tbl.push_back(v(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0));
      tbl.push_back(v(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0, 0));
      tbl.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0));
      tbl.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0));
      // Owner 2: non-owner done and new requests ignored, then req drop releases
      tbl.push_back(v(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0));
      tbl.push_back(v(0, 4'b0100, 4'b0001, 4'b0100, 2'd2, 1, 0));
      tbl.push_back(v(0, 4'b0110, 4'b0010, 4'b0100, 2'd2, 1, 0));
      tbl.push_back(v(0, 4'b0010, 4'b0000, 4'b0000, 2'd0, 0, 0));
      tbl.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0));
      run_table("rr");

      // Single requester never releasing: 8 grant cycles, timeout, regrant
      step(0, 4'b0001, 4'b0000);
      check("hold0", 4'b0001, 2'd0, 1, 0);
      for (int i = 1; i < 8; i++) begin
         step(0, 4'b0001, 4'b0000);
         check($sformatf("hold%0d", i), 4'b0001, 2'd0, 1, 0);
      end
      step(0, 4'b0001, 4'b0000);
      check("timeout_pulse", 4'b0000, 2'd0, 0, 1);
      step(0, 4'b0001, 4'b0000);
      check("regrant", 4'b0001, 2'd0, 1, 0);

      // done coinciding with the hold limit: release without timeout
      for (int i = 1; i < 8; i++)
         step(0, 4'b0001, 4'b0000);
      check("pre_limit", 4'b0001, 2'd0, 1, 0);
      step(0, 4'b0001, 4'b0001);
      check("done_at_limit", 4'b0000, 2'd0, 0, 0);
      step(0, 4'b0000, 4'b0000);
      check("back_idle", 4'b0000, 2'd0, 0, 0);

      // Reset mid-grant restores the pointer
      tbl.push_back(v(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0));
      tbl.push_back(v(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0));
      tbl.push_back(v(1, 4'b0011, 4'b0000, 4'b0000, 2'd0, 0, 0));
      tbl.push_back(v(0, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 0));
      tbl.push_back(v(0, 4'b0100, 4'b0000, 4'b0000, 2'd0, 0, 0));
      tbl.push_back(v(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0));
      tbl.push_back(v(1, 4'b1100, 4'b0000, 4'b0000, 2'd0, 0, 0));
      tbl.push_back(v(0, 4'b1100, 4'b0000, 4'b0100, 2'd2, 1, 0));
      tbl.push_back(v(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0));
      run_table("rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_four_way_rr_arbiter
`default_nettype wire
